// File: rtl/thinpad_top_bus_pkg.sv
// Shared definitions for the Thinpad bus bridge: address map defaults,
// bridge FSM states and the byte-enable polarity helper.
package thinpad_top_bus_pkg;

  localparam logic [31:0] DEF_RAM_BASE       = 32'h8000_0000;
  localparam logic [31:0] DEF_UART_DATA_ADDR = 32'hBFD0_03F8;
  localparam logic [31:0] DEF_UART_STAT_ADDR = 32'hBFD0_03FC;
  localparam logic [31:0] DEF_LED_ADDR       = 32'hBFD0_0400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR1,
    S_WR2,
    S_DONE
  } bus_state_t;

  function automatic logic [3:0] be_to_be_n(input logic [3:0] be);
    return ~be;
  endfunction

endpackage

// File: rtl/thinpad_sram_port.sv
// One asynchronous SRAM bank: latched address/byte enables, strobe registers,
// tristate write buffer and read-data capture, sequenced by the parent FSM.
module thinpad_sram_port
  import thinpad_top_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        open,
  input  logic        open_wr,
  input  logic [19:0] open_addr,
  input  logic [3:0]  open_be_n,
  input  logic [31:0] open_wdata,
  input  logic        we_on,
  input  logic        we_off,
  input  logic        capture,
  input  logic        close,
  output logic [31:0] rd_data,
  inout  wire  [31:0] ram_data,
  output logic [19:0] ram_addr,
  output logic [3:0]  ram_be_n,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  logic        drive;
  logic [31:0] wr_q;

  assign ram_data = drive ? wr_q : 'z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr <= '0;
      ram_be_n <= '1;
      ram_ce_n <= 1'b1;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
      drive    <= 1'b0;
      wr_q     <= '0;
      rd_data  <= '0;
    end else begin
      if (open) begin
        ram_addr <= open_addr;
        ram_be_n <= open_be_n;
        ram_ce_n <= 1'b0;
        ram_oe_n <= open_wr;
        drive    <= open_wr;
        wr_q     <= open_wdata;
      end
      if (we_on)  ram_we_n <= 1'b0;
      if (we_off) ram_we_n <= 1'b1;
      // A read releases the bank in the same edge that samples the bus.
      if (capture) begin
        rd_data  <= ram_data;
        ram_ce_n <= 1'b1;
        ram_oe_n <= 1'b1;
      end
      if (close) begin
        ram_ce_n <= 1'b1;
        ram_oe_n <= 1'b1;
        drive    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/thinpad_top_bus.sv
// CPU-to-board bus bridge: decodes single word requests onto BaseRAM/ExtRAM,
// the UART byte interface and the LED register; Flash is parked idle.
module thinpad_top_bus
  import thinpad_top_bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE       = DEF_RAM_BASE,
  parameter logic [31:0] UART_DATA_ADDR = DEF_UART_DATA_ADDR,
  parameter logic [31:0] UART_STAT_ADDR = DEF_UART_STAT_ADDR,
  parameter logic [31:0] LED_ADDR       = DEF_LED_ADDR
) (
  input  logic        clk_50M,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  inout  wire  [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,
  inout  wire  [31:0] ext_ram_data,
  output logic [19:0] ext_ram_addr,
  output logic [3:0]  ext_ram_be_n,
  output logic        ext_ram_ce_n,
  output logic        ext_ram_oe_n,
  output logic        ext_ram_we_n,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_start,
  input  logic        uart_tx_busy,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_ready,
  output logic        uart_rx_clear,
  output logic [15:0] leds,
  output logic [22:0] flash_a,
  inout  wire  [15:0] flash_d,
  output logic        flash_rp_n,
  output logic        flash_vpen,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n,
  output logic        flash_byte_n
);

  bus_state_t  state, next_state;
  logic        ram_hit, is_uart_data, is_uart_stat, is_led;
  logic        accept_ram, accept_periph, ram_ack;
  logic        we_on, we_off, capture, close;
  logic        bank_q, from_ram_q;
  logic [31:0] periph_rd_q, base_rd, ext_rd;
  logic        unused_addr_bits;

  assign flash_a      = '0;
  assign flash_d      = 'z;
  assign flash_rp_n   = 1'b1;
  assign flash_vpen   = 1'b1;
  assign flash_ce_n   = 1'b1;
  assign flash_oe_n   = 1'b1;
  assign flash_we_n   = 1'b1;
  assign flash_byte_n = 1'b1;

  assign unused_addr_bits = ^addr[1:0];
  assign ram_hit      = (addr[31:23] == RAM_BASE[31:23]);
  assign is_uart_data = (addr[31:2] == UART_DATA_ADDR[31:2]);
  assign is_uart_stat = (addr[31:2] == UART_STAT_ADDR[31:2]);
  assign is_led       = (addr[31:2] == LED_ADDR[31:2]);

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state    = state;
    accept_ram    = 1'b0;
    accept_periph = 1'b0;
    ram_ack       = 1'b0;
    we_on         = 1'b0;
    we_off        = 1'b0;
    capture       = 1'b0;
    close         = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (ram_hit) begin
            accept_ram = 1'b1;
            next_state = we ? S_WR1 : S_RD;
          end else begin
            accept_periph = 1'b1;
            next_state    = S_DONE;
          end
        end
      end
      S_RD: begin
        capture    = 1'b1;
        ram_ack    = 1'b1;
        next_state = S_DONE;
      end
      S_WR1: begin
        we_on      = 1'b1;
        next_state = S_WR2;
      end
      S_WR2: begin
        we_off     = 1'b1;
        ram_ack    = 1'b1;
        next_state = S_DONE;
      end
      S_DONE: begin
        close      = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      ack           <= 1'b0;
      bank_q        <= 1'b0;
      from_ram_q    <= 1'b0;
      periph_rd_q   <= '0;
      leds          <= '0;
      uart_tx_data  <= '0;
      uart_tx_start <= 1'b0;
      uart_rx_clear <= 1'b0;
    end else begin
      ack           <= ram_ack | accept_periph;
      uart_tx_start <= 1'b0;
      uart_rx_clear <= 1'b0;
      if (accept_ram) begin
        bank_q     <= addr[22];
        from_ram_q <= 1'b1;
      end
      if (accept_periph) begin
        from_ram_q  <= 1'b0;
        periph_rd_q <= '0;
        if (we) begin
          if (is_uart_data) begin
            uart_tx_data  <= wdata[7:0];
            uart_tx_start <= 1'b1;
          end
          if (is_led) begin
            for (int unsigned i = 0; i < 2; i++)
              if (be[i]) leds[8*i +: 8] <= wdata[8*i +: 8];
          end
        end else if (is_uart_data) begin
          periph_rd_q   <= {24'b0, uart_rx_data};
          uart_rx_clear <= 1'b1;
        end else if (is_uart_stat) begin
          periph_rd_q <= {30'b0, uart_rx_ready, ~uart_tx_busy};
        end
      end
    end
  end

  // Read data is selected from whichever source the last accepted request used.
  assign rdata = from_ram_q ? (bank_q ? ext_rd : base_rd) : periph_rd_q;

  thinpad_sram_port u_base (
    .clk        (clk_50M),
    .rst_n      (reset_n),
    .open       (accept_ram & ~addr[22]),
    .open_wr    (we),
    .open_addr  (addr[21:2]),
    .open_be_n  (be_to_be_n(be)),
    .open_wdata (wdata),
    .we_on      (we_on & ~bank_q),
    .we_off     (we_off & ~bank_q),
    .capture    (capture & ~bank_q),
    .close      (close),
    .rd_data    (base_rd),
    .ram_data   (base_ram_data),
    .ram_addr   (base_ram_addr),
    .ram_be_n   (base_ram_be_n),
    .ram_ce_n   (base_ram_ce_n),
    .ram_oe_n   (base_ram_oe_n),
    .ram_we_n   (base_ram_we_n)
  );

  thinpad_sram_port u_ext (
    .clk        (clk_50M),
    .rst_n      (reset_n),
    .open       (accept_ram & addr[22]),
    .open_wr    (we),
    .open_addr  (addr[21:2]),
    .open_be_n  (be_to_be_n(be)),
    .open_wdata (wdata),
    .we_on      (we_on & bank_q),
    .we_off     (we_off & bank_q),
    .capture    (capture & bank_q),
    .close      (close),
    .rd_data    (ext_rd),
    .ram_data   (ext_ram_data),
    .ram_addr   (ext_ram_addr),
    .ram_be_n   (ext_ram_be_n),
    .ram_ce_n   (ext_ram_ce_n),
    .ram_oe_n   (ext_ram_oe_n),
    .ram_we_n   (ext_ram_we_n)
  );

endmodule

// File: tb/tb_thinpad_top_bus.sv
// Bench for thinpad_top_bus: SRAM device models on both banks, a transaction
// level reference model, and one per-cycle compare process.
module tb_thinpad_top_bus;

  logic        clk_50M = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic [31:0] rdata;
  logic        ack;
  wire  [31:0] base_ram_data, ext_ram_data;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic [3:0]  base_ram_be_n, ext_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start;
  logic        uart_tx_busy = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_ready = 1'b0;
  logic        uart_rx_clear;
  logic [15:0] leds;
  logic [22:0] flash_a;
  wire  [15:0] flash_d;
  logic        flash_rp_n, flash_vpen, flash_ce_n, flash_oe_n, flash_we_n, flash_byte_n;

  thinpad_top_bus dut (
    .clk_50M(clk_50M), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .rdata(rdata), .ack(ack),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr),
    .base_ram_be_n(base_ram_be_n), .base_ram_ce_n(base_ram_ce_n),
    .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr),
    .ext_ram_be_n(ext_ram_be_n), .ext_ram_ce_n(ext_ram_ce_n),
    .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n),
    .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
    .uart_tx_busy(uart_tx_busy), .uart_rx_data(uart_rx_data),
    .uart_rx_ready(uart_rx_ready), .uart_rx_clear(uart_rx_clear),
    .leds(leds), .flash_a(flash_a), .flash_d(flash_d),
    .flash_rp_n(flash_rp_n), .flash_vpen(flash_vpen), .flash_ce_n(flash_ce_n),
    .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n), .flash_byte_n(flash_byte_n)
  );

  always #10 clk_50M = ~clk_50M;

  // Asynchronous SRAM device models (1K words each is enough for the bench).
  logic [31:0] base_mem [0:1023];
  logic [31:0] ext_mem  [0:1023];

  assign base_ram_data = (base_ram_ce_n == 1'b0 && base_ram_oe_n == 1'b0) ?
                         base_mem[base_ram_addr[9:0]] : 'z;
  assign ext_ram_data  = (ext_ram_ce_n == 1'b0 && ext_ram_oe_n == 1'b0) ?
                         ext_mem[ext_ram_addr[9:0]] : 'z;

  always @(posedge base_ram_we_n)
    if (base_ram_ce_n == 1'b0)
      for (int b = 0; b < 4; b++)
        if (!base_ram_be_n[b]) base_mem[base_ram_addr[9:0]][8*b +: 8] = base_ram_data[8*b +: 8];

  always @(posedge ext_ram_we_n)
    if (ext_ram_ce_n == 1'b0)
      for (int b = 0; b < 4; b++)
        if (!ext_ram_be_n[b]) ext_mem[ext_ram_addr[9:0]][8*b +: 8] = ext_ram_data[8*b +: 8];

  // Reference state and expectations of the transaction in flight.
  logic [31:0] ref_base [0:1023];
  logic [31:0] ref_ext  [0:1023];
  logic [15:0] ref_leds = '0, pend_leds = '0;
  int          n_checks = 0, n_fail = 0;
  logic        in_txn = 1'b0, got_ack = 1'b0;
  int          lat, we_low, tx_cnt, rxclr_cnt;
  int          exp_lat, exp_bank, exp_we_low, exp_tx, exp_rxclr;
  logic        exp_rd;
  logic [31:0] exp_rdata, last_rdata;
  logic [7:0]  exp_tx_data;
  logic [19:0] exp_waddr;
  logic [3:0]  exp_be_n;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b);
    logic [31:0] mask, old;
    logic [19:0] widx;
    exp_rd = ~w; exp_rdata = '0; exp_bank = 0; exp_we_low = 0;
    exp_tx = 0; exp_rxclr = 0; exp_lat = 1; exp_tx_data = '0;
    pend_leds = ref_leds;
    widx = a[21:2];
    exp_waddr = widx;
    exp_be_n = ~b;
    if (a >= 32'h8000_0000 && a < 32'h8080_0000) begin
      exp_bank = a[22] ? 2 : 1;
      old = a[22] ? ref_ext[widx[9:0]] : ref_base[widx[9:0]];
      if (w) begin
        mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        if (a[22]) ref_ext[widx[9:0]]  = (old & ~mask) | (d & mask);
        else       ref_base[widx[9:0]] = (old & ~mask) | (d & mask);
        exp_lat = 3; exp_we_low = 1;
      end else begin
        exp_rdata = old; exp_lat = 2;
      end
    end else if ((a & ~32'h3) == 32'hBFD0_03F8) begin
      if (w) begin exp_tx = 1; exp_tx_data = d[7:0]; end
      else begin exp_rdata = {24'h0, uart_rx_data}; exp_rxclr = 1; end
    end else if ((a & ~32'h3) == 32'hBFD0_03FC) begin
      if (!w) exp_rdata = {30'h0, uart_rx_ready, !uart_tx_busy};
    end else if ((a & ~32'h3) == 32'hBFD0_0400) begin
      if (w) begin
        if (b[0]) pend_leds[7:0]  = d[7:0];
        if (b[1]) pend_leds[15:8] = d[15:8];
      end
    end
  endtask

  // The single compare process; samples on the falling edge.
  always @(negedge clk_50M) begin
    check32("flash_ctl", {26'h0, flash_ce_n, flash_oe_n, flash_we_n, flash_rp_n,
                          flash_vpen, flash_byte_n}, 32'h3F);
    check32("flash_a", {9'h0, flash_a}, 32'h0);
    if (in_txn) begin
      lat++;
      if (exp_bank != 1) check32("base_idle_ce_we", {30'h0, base_ram_ce_n, base_ram_we_n}, 32'h3);
      if (exp_bank != 2) check32("ext_idle_ce_we", {30'h0, ext_ram_ce_n, ext_ram_we_n}, 32'h3);
      if ((exp_bank == 1 && base_ram_we_n == 1'b0) || (exp_bank == 2 && ext_ram_we_n == 1'b0)) begin
        we_low++;
        check32("wr_addr", {12'h0, exp_bank == 1 ? base_ram_addr : ext_ram_addr}, {12'h0, exp_waddr});
        check32("wr_be_n", {28'h0, exp_bank == 1 ? base_ram_be_n : ext_ram_be_n}, {28'h0, exp_be_n});
      end
      if (uart_tx_start) begin
        tx_cnt++;
        check32("uart_tx_data", {24'h0, uart_tx_data}, {24'h0, exp_tx_data});
      end
      if (uart_rx_clear) rxclr_cnt++;
      if (ack && !got_ack) begin
        got_ack = 1'b1;
        last_rdata = rdata;
        ref_leds = pend_leds;
        // The first counted falling edge precedes the edge that accepts req.
        check32("ack_latency", lat, exp_lat + 1);
        if (exp_rd) check32("rdata", rdata, exp_rdata);
        check32("we_low_cycles", we_low, exp_we_low);
        check32("tx_start_pulses", tx_cnt, exp_tx);
        check32("rx_clear_pulses", rxclr_cnt, exp_rxclr);
      end
    end else begin
      check32("idle_ack", {31'h0, ack}, 32'h0);
      check32("idle_uart_pulses", {30'h0, uart_tx_start, uart_rx_clear}, 32'h0);
      check32("idle_strobes", {26'h0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n,
                               ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 32'h3F);
    end
    check32("leds", {16'h0, leds}, {16'h0, ref_leds});
  end

  task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b);
    int n;
    model(w, a, d, b);
    lat = 0; we_low = 0; tx_cnt = 0; rxclr_cnt = 0; got_ack = 1'b0;
    in_txn = 1'b1;
    we = w; addr = a; wdata = d; be = b; req = 1'b1;
    n = 0;
    while (!got_ack && n < 20) begin
      @(posedge clk_50M);
      n++;
    end
    if (!got_ack) begin
      n_checks++; n_fail++;
      $display("FAIL ack_timeout: no ack within %0d cycles for addr %h", n, a);
    end
    #1;
    req = 1'b0; we = 1'b0;
    in_txn = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check32("rst_ack_rdata", rdata | {31'h0, ack}, 32'h0);
    check32("rst_leds", {16'h0, leds}, 32'h0);
    check32("rst_strobes", {26'h0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n,
                            ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 32'h3F);
    check32("rst_be_n", {24'h0, base_ram_be_n, ext_ram_be_n}, 32'hFF);
    check32("rst_addr", {12'h0, base_ram_addr | ext_ram_addr}, 32'h0);
    check32("rst_uart", {30'h0, uart_tx_start, uart_rx_clear}, 32'h0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    repeat (3) @(posedge clk_50M);
    #1;
    check_reset_outputs();
    reset_n = 1'b1;
    @(posedge clk_50M); #1;

    // Give both banks known contents through the bridge itself.
    for (int i = 0; i < 256; i++) begin
      run(1'b1, 32'h8000_0000 + i * 4, $urandom, 4'hF);
      run(1'b1, 32'h8040_0000 + i * 4, $urandom, 4'hF);
    end

    run(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    run(1'b0, 32'h8000_0010, 32'h0, 4'hF);
    check32("lit_base_read", last_rdata, 32'hDEAD_BEEF);

    run(1'b1, 32'h8040_0000, 32'h1122_3344, 4'hF);
    run(1'b1, 32'h8040_0000, 32'hAABB_CCDD, 4'b0011);
    run(1'b0, 32'h8040_0000, 32'h0, 4'hF);
    check32("lit_ext_partial", last_rdata, 32'h1122_CCDD);

    run(1'b1, 32'h8040_0000, 32'h5555_5555, 4'b0000);
    run(1'b0, 32'h8040_0000, 32'h0, 4'hF);
    check32("lit_be_zero", last_rdata, 32'h1122_CCDD);

    uart_tx_busy = 1'b0; uart_rx_ready = 1'b0;
    run(1'b0, 32'hBFD0_03FC, 32'h0, 4'hF);
    check32("lit_stat_tx", last_rdata, 32'h1);
    run(1'b1, 32'hBFD0_03F8, 32'h41, 4'hF);
    check32("lit_tx_data", {24'h0, uart_tx_data}, 32'h41);

    uart_rx_ready = 1'b1; uart_rx_data = 8'h5A;
    run(1'b0, 32'hBFD0_03FC, 32'h0, 4'hF);
    check32("lit_stat_rx", last_rdata, 32'h3);
    run(1'b0, 32'hBFD0_03F8, 32'h0, 4'hF);
    check32("lit_rx_data", last_rdata, 32'h5A);

    run(1'b0, 32'h0000_1000, 32'h0, 4'hF);
    check32("lit_unmapped", last_rdata, 32'h0);
    run(1'b1, 32'hBFD0_0400, 32'h0000_00A5, 4'hF);
    check32("lit_leds", {16'h0, leds}, 32'h00A5);

    // Randomized traffic over every region.
    for (int i = 0; i < 200; i++) begin
      uart_tx_busy  = 1'($urandom);
      uart_rx_ready = 1'($urandom);
      uart_rx_data  = 8'($urandom);
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000 + $urandom_range(0, 255) * 4 + $urandom_range(0, 3);
        1: a = 32'h8040_0000 + $urandom_range(0, 255) * 4 + $urandom_range(0, 3);
        2: a = 32'hBFD0_03F8;
        3: a = 32'hBFD0_03FC;
        4: a = 32'hBFD0_0400;
        default: a = 32'h1000_0000 + $urandom_range(0, 4095) * 4;
      endcase
      run(1'($urandom), a, $urandom, 4'($urandom));
    end

    // Abort a BaseRAM write while we_n is low.
    lat = 0; we_low = 0; tx_cnt = 0; rxclr_cnt = 0; got_ack = 1'b0;
    exp_bank = 1; exp_waddr = 20'd1000; exp_be_n = 4'h0;
    in_txn = 1'b1;
    we = 1'b1; addr = 32'h8000_0FA0; wdata = 32'hCAFE_F00D; be = 4'hF; req = 1'b1;
    @(posedge clk_50M);
    @(posedge clk_50M); #2;
    check32("abort_we_low", {31'h0, base_ram_we_n}, 32'h0);
    ref_leds = '0;
    reset_n = 1'b0;
    #1;
    check32("abort_strobes", {29'h0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n}, 32'h7);
    check32("abort_ack", {31'h0, ack}, 32'h0);
    n_checks++;
    if (base_ram_data === 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL abort_bus: got %h expected released bus", base_ram_data);
    end
    req = 1'b0; we = 1'b0; in_txn = 1'b0;
    repeat (2) @(posedge clk_50M);
    #1;
    check_reset_outputs();
    reset_n = 1'b1;
    @(posedge clk_50M); #1;
    run(1'b0, 32'h8000_0010, 32'h0, 4'hF);
    check32("lit_after_abort", last_rdata, 32'hDEAD_BEEF);

    repeat (3) @(posedge clk_50M);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
